// File: rtl/wbs_kdtree_node_slave_pkg.sv
// kdtree_wbs_pkg: shared types and constants for the KD-tree node-load Wishbone slave
// Provides node field width, the {median, index} node record, status register constants,
// the slave FSM state type and an offset range helper.
package kdtree_wbs_pkg;
    localparam int DATA_WIDTH     = 11;
    localparam int STATUS_OFF     = 0;
    localparam int STATUS_CLR_BIT = 0;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] median;
        logic [DATA_WIDTH-1:0] index;
    } node_t;
    typedef enum logic [2:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK, HOLD} state_t;
    function automatic logic is_node_off(input int off, input int num_nodes);
        return off >= 1 && off <= num_nodes;
    endfunction
endpackage

// File: rtl/wbs_kdtree_node_slave_if.sv
// wbs_kdtree_node_slave_if: Wishbone classic-cycle bus between the management core and the node slave
// Signals: cyc/stb/we/sel/adr/dat_i from the master; ack/dat_o (and err when WBS_NODE_ERR_EN) from the slave.
interface wbs_kdtree_node_slave_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef WBS_NODE_ERR_EN
    logic        wbs_err_o;
`endif
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
`ifdef WBS_NODE_ERR_EN
        , output wbs_err_o
`endif
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
`ifdef WBS_NODE_ERR_EN
        , input wbs_err_o
`endif
    );
endinterface

// File: rtl/wbs_kdtree_node_slave_tracker.sv
// node_valid_tracker: remembers which heap nodes 1..NUM_NODES have been loaded since the last clear
// Ports: clk/rst_n clock and async active-low reset; set_en/set_idx mark a node loaded;
//   clr empties the bitmap; count = loaded nodes; nodes_loaded = every node loaded (registered).
module node_valid_tracker #(
    parameter int NUM_NODES  = 63,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  nodes_loaded
);
    logic [NUM_NODES:1] map_q, map_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic loaded_q;
    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        if (clr) begin
            map_d = '0;
            cnt_d = '0;
        end else if (set_en && !map_q[set_idx]) begin
            map_d[set_idx] = 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            map_q    <= map_d;
            cnt_q    <= cnt_d;
            loaded_q <= &map_d;
        end
    end
    assign count        = cnt_q;
    assign nodes_loaded = loaded_q;
endmodule

// File: rtl/wbs_kdtree_node_slave.sv
// wbs_kdtree_node_slave: Wishbone classic slave that loads KD-tree internal nodes into node memory
// Ports: wb_clk_i/rst_n clock and async active-low reset; wbs Wishbone slave bus;
//   node_wen/node_waddr/node_wdata node memory write; node_ren/node_raddr/node_rdata node memory read;
//   nodes_loaded set once every node has been written since the last clear.
// Build option: WBS_NODE_ERR_EN answers partial-sel node writes and invalid offsets with wbs_err_o.
module wbs_kdtree_node_slave
    import kdtree_wbs_pkg::*;
#(
    parameter int          NUM_NODES  = 63,
    parameter int          ADDR_WIDTH = $clog2(NUM_NODES + 1),
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    rst_n,
    wbs_kdtree_node_slave_if.slave  wbs,
    output logic                    node_wen,
    output logic [ADDR_WIDTH-1:0]   node_waddr,
    output logic [2*DATA_WIDTH-1:0] node_wdata,
    output logic                    node_ren,
    output logic [ADDR_WIDTH-1:0]   node_raddr,
    input  logic [2*DATA_WIDTH-1:0] node_rdata,
    output logic                    nodes_loaded
);
    state_t state_q;
    logic rsp_q, err_q, clr_q;
    logic [31:0] dat_q;
    logic cs, hit, is_stat, is_node, full_sel, bad;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH:0] count;
    logic [31:0] status;
    node_t wr_node;
    assign cs       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit      = cs && wbs.wbs_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
    assign off      = wbs.wbs_adr_i[ADDR_WIDTH-1:0];
    assign is_stat  = off == ADDR_WIDTH'(STATUS_OFF);
    assign is_node  = is_node_off(int'(off), NUM_NODES);
    assign full_sel = &wbs.wbs_sel_i[2:0];
    assign wr_node  = '{median: wbs.wbs_dat_i[2*DATA_WIDTH-1:DATA_WIDTH], index: wbs.wbs_dat_i[DATA_WIDTH-1:0]};
    assign status   = {15'b0, nodes_loaded, 9'b0, 7'(count)};
`ifdef WBS_NODE_ERR_EN
    assign bad = wbs.wbs_we_i ? !(is_stat || (is_node && full_sel)) : !(is_stat || is_node);
    assign wbs.wbs_err_o = rsp_q & err_q;
`else
    assign bad = 1'b0;
`endif
    // rsp_q marks the single response cycle; err_q selects whether it is an ack or an error.
    assign wbs.wbs_ack_o = rsp_q & ~err_q;
    assign wbs.wbs_dat_o = dat_q;
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_q      <= 1'b0;
            err_q      <= 1'b0;
            clr_q      <= 1'b0;
            dat_q      <= '0;
            node_wen   <= 1'b0;
            node_waddr <= '0;
            node_wdata <= '0;
            node_ren   <= 1'b0;
            node_raddr <= '0;
        end else begin
            rsp_q    <= 1'b0;
            node_wen <= 1'b0;
            clr_q    <= 1'b0;
            case (state_q)
                IDLE: if (hit) begin
                    // node reads respond only after the memory read cycle
                    rsp_q <= wbs.wbs_we_i || !is_node;
                    err_q <= bad;
                    if (wbs.wbs_we_i) begin
                        state_q <= WR_ACK;
                        clr_q   <= is_stat && wbs.wbs_dat_i[STATUS_CLR_BIT];
                        if (is_node && full_sel) begin
                            node_wen   <= 1'b1;
                            node_waddr <= off;
                            node_wdata <= wr_node;
                        end
                    end else if (is_node) begin
                        state_q    <= RD_WAIT;
                        node_ren   <= 1'b1;
                        node_raddr <= off;
                    end else begin
                        state_q <= RD_ACK;
                        dat_q   <= is_stat ? status : '0;
                    end
                end
                WR_ACK, RD_ACK: state_q <= HOLD;
                RD_WAIT: begin
                    node_ren <= 1'b0;
                    state_q  <= cs ? RD_ACK : IDLE;
                    if (cs) begin
                        rsp_q <= 1'b1;
                        err_q <= 1'b0;
                        dat_q <= 32'(node_rdata);
                    end
                end
                HOLD: if (!cs || hit) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // node_wen/clr_q are high only during WR_ACK, so the bitmap updates as that cycle ends.
    node_valid_tracker #(.NUM_NODES(NUM_NODES), .ADDR_WIDTH(ADDR_WIDTH)) u_tracker (
        .clk          (wb_clk_i),
        .rst_n        (rst_n),
        .set_en       (node_wen),
        .set_idx      (node_waddr),
        .clr          (clr_q),
        .count        (count),
        .nodes_loaded (nodes_loaded)
    );
endmodule

// File: tb/tb_wbs_kdtree_node_slave.sv
// tb_wbs_kdtree_node_slave: scoreboard bench for the KD-tree node-load Wishbone slave
module tb_wbs_kdtree_node_slave;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WBS_NODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    typedef struct { bit err; bit chk; logic [31:0] dat; int lat; } rsp_t;
    typedef struct { logic [5:0] a; logic [21:0] d; } wr_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic node_wen, node_ren, nodes_loaded;
    logic [5:0] node_waddr, node_raddr;
    logic [21:0] node_wdata, node_rdata;
    logic [21:0] mem [0:63];
    rsp_t rq[$];
    wr_t wq[$];
    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int req_cyc = 0;
    logic prev_rsp = 1'b0;
    wbs_kdtree_node_slave_if bus();
`ifdef WBS_NODE_ERR_EN
    wire err_w = bus.wbs_err_o;
`else
    wire err_w = 1'b0;
`endif
    wbs_kdtree_node_slave dut (
        .wb_clk_i     (clk),
        .rst_n        (rst_n),
        .wbs          (bus),
        .node_wen     (node_wen),
        .node_waddr   (node_waddr),
        .node_wdata   (node_wdata),
        .node_ren     (node_ren),
        .node_raddr   (node_raddr),
        .node_rdata   (node_rdata),
        .nodes_loaded (nodes_loaded)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (node_wen) mem[node_waddr] <= node_wdata;
    end
    assign node_rdata = mem[node_raddr];

    always @(negedge clk) begin
        rsp_t e;
        wr_t w;
        int lat;
        if (bus.wbs_ack_o || err_w) begin
            checks++;
            lat = cyc_n - req_cyc;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b dat=%h, required no response", bus.wbs_ack_o, err_w, bus.wbs_dat_o);
            end else begin
                e = rq.pop_front();
                if (prev_rsp || err_w !== e.err || bus.wbs_ack_o === e.err || lat != e.lat || (e.chk && bus.wbs_dat_o !== e.dat)) begin
                    failures++;
                    $display("FAIL resp: ack=%0b err=%0b lat=%0d dat=%h back_to_back=%0b, required err=%0b lat=%0d dat=%h (checked=%0b)",
                             bus.wbs_ack_o, err_w, lat, bus.wbs_dat_o, prev_rsp, e.err, e.lat, e.dat, e.chk);
                end
            end
        end
        prev_rsp <= bus.wbs_ack_o | err_w;
        if (node_wen) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_wen: addr=%0d data=%h, required no write", node_waddr, node_wdata);
            end else begin
                w = wq.pop_front();
                if (node_waddr !== w.a || node_wdata !== w.d) begin
                    failures++;
                    $display("FAIL node_write: addr=%0d data=%h, required addr=%0d data=%h", node_waddr, node_wdata, w.a, w.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.wbs_cyc_i = c;
        bus.wbs_stb_i = c;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int n = 0;
        @(negedge clk);
        drive(1'b1, we, adr, dat, sel);
        req_cyc = cyc_n;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(bus.wbs_ack_o || err_w) && n < 8);
        if (n >= 8) begin
            checks++;
            failures++;
            $display("FAIL timeout: no response to adr=%h within 8 cycles", adr);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
    endtask

    task automatic wr(input int off, input logic [31:0] dat, input logic [3:0] sel, input bit mem_wr, input bit err);
        rq.push_back('{err: err, chk: 1'b0, dat: 32'h0, lat: 1});
        if (mem_wr) wq.push_back('{a: 6'(off), d: dat[21:0]});
        xfer(1'b1, BASE + 32'(off), dat, sel);
    endtask

    task automatic rd(input int off, input logic [31:0] exp, input int lat);
        rq.push_back('{err: 1'b0, chk: 1'b1, dat: exp, lat: lat});
        xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF);
    endtask

    function automatic logic [21:0] nd(input int i, input int v);
        return {11'((i * 37 + v * 101 + 5) % 2048), 11'(i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        chk("rst_ack", 32'(bus.wbs_ack_o), 0);
        chk("rst_dat", bus.wbs_dat_o, 0);
        chk("rst_wen", 32'(node_wen), 0);
        chk("rst_ren", 32'(node_ren), 0);
        chk("rst_waddr", 32'(node_waddr), 0);
        chk("rst_loaded", 32'(nodes_loaded), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(1, {10'b0, 11'd55, 11'd1}, 4'hF, 1'b1, 1'b0);
        rd(0, 32'h0000_0001, 1);
        wr(5, {10'h3FF, nd(5, 0)}, 4'hF, 1'b1, 1'b0);
        wr(5, {10'h3FF, nd(5, 1)}, 4'hF, 1'b1, 1'b0);
        rd(5, 32'(nd(5, 1)), 2);
        rd(0, 32'h0000_0002, 1);
        wr(9, {10'h0, nd(9, 0)}, 4'b0011, 1'b0, ERR_EN);
        rd(0, 32'h0000_0002, 1);
        for (int i = 1; i <= 63; i++) begin
            if (i == 63) chk("loaded_before_last", 32'(nodes_loaded), 0);
            wr(i, {10'h2A5, nd(i, 2)}, 4'hF, 1'b1, 1'b0);
            rd(i, 32'(nd(i, 2)), 2);
        end
        chk("loaded_after_all", 32'(nodes_loaded), 1);
        rd(0, 32'h0001_003F, 1);
        rd(6, 32'(nd(6, 2)), 2);
        @(negedge clk);
        drive(1'b1, 1'b0, BASE + 32'd7, 32'h0, 4'hF);
        req_cyc = cyc_n;
        @(negedge clk);
        chk("abort_ren", 32'(node_ren), 1);
        chk("abort_raddr", 32'(node_raddr), 7);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("abort_dat_hold", bus.wbs_dat_o, 32'(nd(6, 2)));
        rd(7, 32'(nd(7, 2)), 2);
        @(negedge clk);
        drive(1'b1, 1'b1, BASE + 32'h40, 32'h0000_1234, 4'hF);
        repeat (4) @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        wr(0, 32'h0000_0001, 4'hF, 1'b0, 1'b0);
        chk("loaded_after_clear", 32'(nodes_loaded), 0);
        rd(0, 32'h0000_0000, 1);
        @(negedge clk);
        drive(1'b1, 1'b1, BASE + 32'd3, {10'h0, nd(3, 3)}, 4'hF);
        @(posedge clk);
        #2;
        chk("midwr_ack", 32'(bus.wbs_ack_o), 1);
        chk("midwr_wen", 32'(node_wen), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ack", 32'(bus.wbs_ack_o), 0);
        chk("async_rst_wen", 32'(node_wen), 0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rsp_queue_empty", 32'(rq.size()), 0);
        chk("wr_queue_empty", 32'(wq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
